pipe_shifter: RTL and testbench

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/shifter_pkg.sv | 11 +
 rtl/shift_stage.sv | 61 ++++++
 rtl/pipe_shifter.sv | 76 +++++++
 tb/tb_pipe_shifter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// Shared types for the pipelined barrel shifter.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROL = 2'b11
    } shift_mode_t;

endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter pipeline stage: conditionally shifts by a fixed AMOUNT and
// registers the result together with its side-band (amount, mode, sign).
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int AMOUNT = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_ld,
    input  logic                       i_valid,
    input  logic [WIDTH-1:0]           i_data,
    input  logic [$clog2(WIDTH)-1:0]   i_by,
    input  shift_mode_t                i_mode,
    input  logic                       i_sign,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(WIDTH)-1:0]   o_by,
    output shift_mode_t                o_mode,
    output logic                       o_sign
);

    localparam int BIT = $clog2(AMOUNT);

    logic [WIDTH-1:0] w_shifted;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_shifted = i_data;
        case (i_mode)
            SH_SLL:  w_shifted = i_data << AMOUNT;
            SH_SRL:  w_shifted = i_data >> AMOUNT;
            SH_SRA:  w_shifted = {{AMOUNT{i_sign}}, i_data[WIDTH-1:AMOUNT]};
            SH_ROL:  w_shifted = {i_data[WIDTH-1-AMOUNT:0], i_data[WIDTH-1 -: AMOUNT]};
            default: w_shifted = i_data;
        endcase
    end

    assign w_next = i_by[BIT] ? w_shifted : i_data;

    // Payload only loads with a real request, so a bubble never disturbs held data.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_by    <= '0;
            o_mode  <= SH_SLL;
            o_sign  <= 1'b0;
        end else if (i_ld) begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_data <= w_next;
                o_by   <= i_by;
                o_mode <= i_mode;
                o_sign <= i_sign;
            end
        end
    end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter with valid/ready flow control: one stage per
// shift-amount bit, MSB first, with full-throughput elastic handshaking.
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           v,
    input  logic [$clog2(WIDTH)-1:0]   by,
    input  shift_mode_t                mode,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           s
);

    localparam int SW = $clog2(WIDTH);

    logic [SW-1:0]    w_vld;
    logic [SW-1:0]    w_ld;
    logic [SW-1:0]    w_sign;
    logic [WIDTH-1:0] w_data [SW];
    logic [SW-1:0]    w_by   [SW];
    shift_mode_t      w_mode [SW];

    genvar k;
    generate
        for (k = 0; k < SW; k++) begin : g_stage
            // A stage may load when the consumer takes data or any stage from
            // here to the output is empty (a bubble will absorb the shift).
            assign w_ld[k] = out_ready | ~(&w_vld[SW-1:k]);

            if (k == 0) begin : g_first
                shift_stage #(.WIDTH(WIDTH), .AMOUNT(1 << (SW-1-k))) u_stage (
                    .i_clk   (clock),
                    .i_rst   (reset),
                    .i_ld    (w_ld[k]),
                    .i_valid (in_valid),
                    .i_data  (v),
                    .i_by    (by),
                    .i_mode  (mode),
                    .i_sign  (v[WIDTH-1]),
                    .o_valid (w_vld[k]),
                    .o_data  (w_data[k]),
                    .o_by    (w_by[k]),
                    .o_mode  (w_mode[k]),
                    .o_sign  (w_sign[k])
                );
            end else begin : g_rest
                shift_stage #(.WIDTH(WIDTH), .AMOUNT(1 << (SW-1-k))) u_stage (
                    .i_clk   (clock),
                    .i_rst   (reset),
                    .i_ld    (w_ld[k]),
                    .i_valid (w_vld[k-1]),
                    .i_data  (w_data[k-1]),
                    .i_by    (w_by[k-1]),
                    .i_mode  (w_mode[k-1]),
                    .i_sign  (w_sign[k-1]),
                    .o_valid (w_vld[k]),
                    .o_data  (w_data[k]),
                    .o_by    (w_by[k]),
                    .o_mode  (w_mode[k]),
                    .o_sign  (w_sign[k])
                );
            end
        end
    endgenerate

    assign in_ready  = w_ld[0];
    assign out_valid = w_vld[SW-1];
    assign s         = w_data[SW-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// Scoreboard bench for pipe_shifter (WIDTH=16): directed vectors, backpressure,
// mid-flight reset and a randomized-ready run against a reference model.
module tb_pipe_shifter;
    import shifter_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] v = '0;
    logic [3:0]  by = '0;
    shift_mode_t mode = SH_SLL;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] s;

    pipe_shifter #(.WIDTH(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .v         (v),
        .by        (by),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          acc_cnt = 0;
    bit          rnd_on = 0;
    bit          prev_stall = 0;
    logic [15:0] prev_s = '0;

    typedef struct {
        logic [15:0] v;
        logic [3:0]  by;
        shift_mode_t m;
        logic [15:0] e;
    } vec_t;

    vec_t dirv[$] = '{
        '{16'h0001, 4'd15, SH_SLL, 16'h8000},
        '{16'h8000, 4'd4,  SH_SRA, 16'hF800},
        '{16'hF000, 4'd12, SH_SRL, 16'h000F},
        '{16'h8001, 4'd1,  SH_ROL, 16'h0003},
        '{16'hA5C3, 4'd0,  SH_SLL, 16'hA5C3},
        '{16'hA5C3, 4'd0,  SH_SRL, 16'hA5C3},
        '{16'hA5C3, 4'd0,  SH_SRA, 16'hA5C3},
        '{16'hA5C3, 4'd0,  SH_ROL, 16'hA5C3},
        '{16'h7FF0, 4'd4,  SH_SRA, 16'h07FF},
        '{16'h1234, 4'd8,  SH_ROL, 16'h3412},
        '{16'hFFFF, 4'd8,  SH_SLL, 16'hFF00},
        '{16'hF00F, 4'd15, SH_SRA, 16'hFFFF},
        '{16'h8421, 4'd15, SH_ROL, 16'hC210},
        '{16'h8000, 4'd15, SH_SRL, 16'h0001}
    };

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] ref_shift(input logic [15:0] x, input logic [3:0] n,
                                              input shift_mode_t m);
        logic [15:0] r;
        case (m)
            SH_SLL:  r = x << n;
            SH_SRL:  r = x >> n;
            SH_SRA:  r = 16'($signed(x) >>> n);
            default: r = (n == 0) ? x : ((x << n) | (x >> (5'd16 - {1'b0, n})));
        endcase
        return r;
    endfunction

    // Hold a request until the DUT takes it; the expectation is queued on the
    // sampled handshake, before the accepting edge.
    task automatic send(input logic [15:0] vv, input logic [3:0] bb, input shift_mode_t mm,
                        input logic [15:0] ee, input bit lat);
        bit done;
        exp_t e;
        done = 0;
        in_valid = 1'b1;
        v = vv;
        by = bb;
        mode = mm;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clock);
            if (in_ready) begin
                e.d = ee;
                e.acc = cyc;
                e.lat = lat;
                exp_q.push_back(e);
                acc_cnt++;
                done = 1;
            end
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        if (!done) chk("send_timeout", 32'(done), 32'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && exp_q.size() != 0; n++) @(posedge clock);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clock);
        #1;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (out_valid && !out_ready) begin
                if (prev_stall) chk("hold_stable", 32'(s), 32'(prev_s));
                prev_stall = 1;
                prev_s = s;
            end else begin
                prev_stall = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_output: got s=%0h, required no output", s);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("result", 32'(s), 32'(e.d));
                    if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd4);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running, required completion");
        $fatal(1);
    end

    initial begin
        int cnt;
        logic [15:0] rv;
        logic [3:0]  rb;
        shift_mode_t rm;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_s", 32'(s), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Directed vectors, first one accepted on the first edge after reset.
        foreach (dirv[i]) send(dirv[i].v, dirv[i].by, dirv[i].m, dirv[i].e, i == 0);
        drain();

        // Backpressure: six requests against a stalled consumer.
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [15:0] ev;
                    case (i)
                        0: ev = 16'h0003;
                        1: ev = 16'h0006;
                        2: ev = 16'h000C;
                        3: ev = 16'h0018;
                        4: ev = 16'h0030;
                        default: ev = 16'h0060;
                    endcase
                    send(16'h0003, 4'(i), SH_SLL, ev, 0);
                end
            end
            begin
                repeat (6) @(posedge clock);
                @(negedge clock);
                chk("bp_accepts", 32'(acc_cnt), 32'd4);
                chk("bp_in_ready", 32'(in_ready), 32'd0);
                chk("bp_out_valid", 32'(out_valid), 32'd1);
                @(posedge clock);
                #2 out_ready = 1'b1;
                cnt = 0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clock);
                    if (out_valid) cnt++;
                end
                chk("bp_stream", 32'(cnt), 32'd6);
            end
        join
        drain();

        // Reset with three requests in flight.
        send(16'h1111, 4'd1, SH_SLL, 16'h2222, 0);
        send(16'h2222, 4'd2, SH_SRL, 16'h0888, 0);
        send(16'h4444, 4'd3, SH_ROL, 16'h2222, 0);
        reset = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_s", 32'(s), 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            if (out_valid) cnt++;
        end
        chk("no_stale", 32'(cnt), 32'd0);
        @(posedge clock);
        #1;
        send(16'h00F0, 4'd4, SH_SLL, 16'h0F00, 1);
        drain();

        // Randomized consumer readiness against the reference model.
        rnd_on = 1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    rv = 16'($urandom);
                    rb = 4'($urandom_range(0, 15));
                    rm = shift_mode_t'($urandom_range(0, 3));
                    send(rv, rb, rm, ref_shift(rv, rb, rm), 0);
                end
                rnd_on = 0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clock);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
